// File: rtl/lgn_pkg.sv
// Shared constants and FSM state type for the logic-gate-network classifier front end.
package lgn_pkg;
  localparam int unsigned INPUTS = 256;
  localparam int unsigned BYTE_W = 8;
  localparam int unsigned BEATS  = INPUTS / BYTE_W;
  localparam int unsigned CNT_W  = (BEATS > 1) ? $clog2(BEATS) : 1;

  typedef enum logic {
    IDLE = 1'b0,
    LOAD = 1'b1
  } state_e;
endpackage

// File: rtl/lgn_input_loader.sv
// Assembles byte beats into a double-buffered binary image and pulses frame_valid on commit.
module lgn_input_loader #(
  parameter int unsigned INPUTS = lgn_pkg::INPUTS,
  parameter int unsigned BYTE_W = lgn_pkg::BYTE_W,
  localparam int unsigned BEATS = INPUTS / BYTE_W,
  localparam int unsigned CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [BYTE_W-1:0] in_data,
  input  logic              in_valid,
  input  logic              in_sof,
  output logic [INPUTS-1:0] frame_out,
  output logic              frame_valid,
  output logic              busy,
  output logic [CNT_W-1:0]  beat_idx,
  output logic              sync_err,
  output logic [7:0]        frame_cnt
);
  import lgn_pkg::*;

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(BEATS - 1);
  localparam logic [CNT_W-1:0] ONE_IDX  = CNT_W'(1);

  state_e              state_q, state_d;
  logic [INPUTS-1:0]   sh_q, sh_d;
  logic [INPUTS-1:0]   frame_q, frame_d;
  logic [CNT_W-1:0]    idx_q, idx_d;
  logic                fv_q, fv_d;
  logic                serr_q, serr_d;
  logic [7:0]          cnt_q, cnt_d;
  logic [INPUTS+BYTE_W-1:0] sh_cat;
  logic                accept;
  logic                commit;

  always_comb begin
    state_d = state_q;
    sh_d    = sh_q;
    frame_d = frame_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    fv_d    = 1'b0;
    serr_d  = 1'b0;
    accept  = 1'b0;
    commit  = 1'b0;
    // Concatenation instead of a part-select keeps the shift legal when BEATS == 1.
    sh_cat  = {sh_q, in_data};

    if (in_valid) begin
      unique case (state_q)
        IDLE: begin
          if (in_sof) begin
            accept = 1'b1;
            if (BEATS == 1) begin
              commit = 1'b1;
            end else begin
              state_d = LOAD;
              idx_d   = ONE_IDX;
            end
          end else begin
            serr_d = 1'b1;
          end
        end
        LOAD: begin
          accept = 1'b1;
          if (in_sof) begin
            serr_d = 1'b1;
            idx_d  = ONE_IDX;
          end else if (idx_q == LAST_IDX) begin
            commit = 1'b1;
          end else begin
            idx_d = idx_q + ONE_IDX;
          end
        end
      endcase
    end

    if (accept) begin
      sh_d = sh_cat[INPUTS-1:0];
    end

    if (commit) begin
      frame_d = sh_cat[INPUTS-1:0];
      cnt_d   = cnt_q + 8'd1;
      idx_d   = '0;
      state_d = IDLE;
      fv_d    = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      sh_q    <= '0;
      frame_q <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
      fv_q    <= 1'b0;
      serr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sh_q    <= sh_d;
      frame_q <= frame_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      fv_q    <= fv_d;
      serr_q  <= serr_d;
    end
  end

  assign frame_out   = frame_q;
  assign frame_valid = fv_q;
  assign busy        = (state_q == LOAD);
  assign beat_idx    = idx_q;
  assign sync_err    = serr_q;
  assign frame_cnt   = cnt_q;
endmodule

// File: tb/tb_lgn_input_loader.sv
// Self-checking bench for lgn_input_loader: byte-list reference model plus commit scoreboard.
module tb_lgn_input_loader;
  import lgn_pkg::*;

  logic              clk;
  logic              rst;
  logic [BYTE_W-1:0] in_data;
  logic              in_valid;
  logic              in_sof;
  logic [INPUTS-1:0] frame_out;
  logic              frame_valid;
  logic              busy;
  logic [CNT_W-1:0]  beat_idx;
  logic              sync_err;
  logic [7:0]        frame_cnt;

  lgn_input_loader #(.INPUTS(INPUTS), .BYTE_W(BYTE_W)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_sof(in_sof),
    .frame_out(frame_out), .frame_valid(frame_valid), .busy(busy), .beat_idx(beat_idx),
    .sync_err(sync_err), .frame_cnt(frame_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [INPUTS-1:0] frame;
    logic [7:0]        cnt;
    int unsigned       cyc;
  } exp_t;

  typedef struct {
    logic              v;
    logic              s;
    logic [BYTE_W-1:0] d;
    logic              busy;
    logic [CNT_W-1:0]  idx;
    logic              serr;
  } vec_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;
  int unsigned cyc = 0;

  logic [BYTE_W-1:0] mbytes[$];
  logic              m_busy = 1'b0;
  logic [7:0]        m_cnt  = '0;
  logic [INPUTS-1:0] m_last = '0;
  logic              p_serr = 1'b0;
  logic              p_fv   = 1'b0;
  bit                have_p = 1'b0;

  task automatic chk(input string n, input logic [INPUTS-1:0] act, input logic [INPUTS-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", n, act, exp, cyc);
    end
  endtask

  function automatic logic [INPUTS-1:0] pack_bytes();
    logic [INPUTS-1:0] f = '0;
    foreach (mbytes[i]) f = {f[INPUTS-BYTE_W-1:0], mbytes[i]};
    return f;
  endfunction

  task automatic check_outputs();
    exp_t e;
    if (!have_p) return;
    chk("busy", INPUTS'(busy), INPUTS'(m_busy));
    chk("beat_idx", INPUTS'(beat_idx), INPUTS'(mbytes.size()));
    chk("sync_err", INPUTS'(sync_err), INPUTS'(p_serr));
    chk("frame_valid", INPUTS'(frame_valid), INPUTS'(p_fv));
    chk("frame_cnt", INPUTS'(frame_cnt), INPUTS'(m_cnt));
    chk("frame_out_hold", frame_out, m_last);
    if (frame_valid === 1'b1) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL sb_unexpected: frame_valid=1 with no commit expected (cycle %0d)", cyc);
      end else begin
        e = sb.pop_front();
        chk("sb_frame", frame_out, e.frame);
        chk("sb_cnt", INPUTS'(frame_cnt), INPUTS'(e.cnt));
        chk("sb_latency", INPUTS'(cyc), INPUTS'(e.cyc));
      end
    end
  endtask

  // Drive one cycle at the falling edge; first check what the previous cycle produced.
  task automatic drive(input logic [BYTE_W-1:0] d, input logic v, input logic s);
    @(negedge clk);
    cyc++;
    check_outputs();
    in_data  = d;
    in_valid = v;
    in_sof   = s;
    p_serr   = 1'b0;
    p_fv     = 1'b0;
    if (v) begin
      if (s) begin
        p_serr = m_busy;
        mbytes.delete();
        mbytes.push_back(d);
        m_busy = 1'b1;
      end else if (!m_busy) begin
        p_serr = 1'b1;
      end else begin
        mbytes.push_back(d);
      end
      if (mbytes.size() == BEATS) begin
        m_last = pack_bytes();
        m_cnt  = m_cnt + 8'd1;
        sb.push_back('{m_last, m_cnt, cyc + 1});
        mbytes.delete();
        m_busy = 1'b0;
        p_fv   = 1'b1;
      end
    end
    have_p = 1'b1;
  endtask

  task automatic idle(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) drive(BYTE_W'($urandom), 1'b0, 1'($urandom));
  endtask

  // kind 0: constant byte; kind 1: base + beat index
  task automatic send_frame(input int kind, input logic [BYTE_W-1:0] base, input int unsigned gap);
    for (int unsigned i = 0; i < BEATS; i++) begin
      drive((kind == 0) ? base : base + BYTE_W'(i), 1'b1, i == 0);
      if (i != BEATS - 1) idle(gap);
    end
  endtask

  // Asserts reset between clock edges and checks the outputs clear without waiting for a clock.
  task automatic reset_check(input string tag);
    #2;
    rst      = 1'b1;
    in_valid = 1'b0;
    in_sof   = 1'b0;
    #1;
    chk({tag, "_frame_out"}, frame_out, '0);
    chk({tag, "_frame_valid"}, INPUTS'(frame_valid), '0);
    chk({tag, "_busy"}, INPUTS'(busy), '0);
    chk({tag, "_beat_idx"}, INPUTS'(beat_idx), '0);
    chk({tag, "_sync_err"}, INPUTS'(sync_err), '0);
    chk({tag, "_frame_cnt"}, INPUTS'(frame_cnt), '0);
    mbytes.delete();
    sb.delete();
    m_busy = 1'b0;
    m_cnt  = '0;
    m_last = '0;
    have_p = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  vec_t tbl[7];

  initial begin
    rst      = 1'b0;
    in_data  = '0;
    in_valid = 1'b0;
    in_sof   = 1'b0;

    // Gapless counting frame.
    reset_check("rst0");
    send_frame(1, 8'h00, 0);
    idle(2);
    chk("cnt_frame_top", INPUTS'(frame_out[INPUTS-1 -: BYTE_W]), INPUTS'(8'h00));
    chk("cnt_frame_low", INPUTS'(frame_out[BYTE_W-1:0]), INPUTS'(8'h1F));

    // Same frame with three idle cycles (random data/sof) between beats.
    reset_check("rst1");
    send_frame(1, 8'h00, 3);
    idle(2);

    // Table: dropped beat in IDLE, sof with valid=0, and a resync mid-frame.
    reset_check("rst2");
    tbl[0] = '{1'b1, 1'b0, 8'h55, 1'b0, CNT_W'(0), 1'b1};
    tbl[1] = '{1'b0, 1'b1, 8'h00, 1'b0, CNT_W'(0), 1'b0};
    tbl[2] = '{1'b1, 1'b1, 8'hFF, 1'b1, CNT_W'(1), 1'b0};
    tbl[3] = '{1'b1, 1'b0, 8'hFF, 1'b1, CNT_W'(2), 1'b0};
    tbl[4] = '{1'b0, 1'b1, 8'h00, 1'b1, CNT_W'(2), 1'b0};
    tbl[5] = '{1'b1, 1'b1, 8'hA5, 1'b1, CNT_W'(1), 1'b1};
    tbl[6] = '{1'b1, 1'b0, 8'hA5, 1'b1, CNT_W'(2), 1'b0};
    for (int i = 0; i < 7; i++) begin
      drive(tbl[i].d, tbl[i].v, tbl[i].s);
      @(posedge clk);
      #1;
      chk($sformatf("tbl%0d_busy", i), INPUTS'(busy), INPUTS'(tbl[i].busy));
      chk($sformatf("tbl%0d_idx", i), INPUTS'(beat_idx), INPUTS'(tbl[i].idx));
      chk($sformatf("tbl%0d_serr", i), INPUTS'(sync_err), INPUTS'(tbl[i].serr));
      chk($sformatf("tbl%0d_fv", i), INPUTS'(frame_valid), '0);
    end
    for (int unsigned i = 2; i < BEATS; i++) drive(8'hA5, 1'b1, 1'b0);
    idle(2);
    chk("tbl_frame_a5", frame_out, {(INPUTS/8){8'hA5}});

    // Ten 0xFF beats abandoned by a new sof, then a full 0xA5 frame.
    reset_check("rst3");
    drive(8'hFF, 1'b1, 1'b1);
    for (int i = 1; i < 10; i++) drive(8'hFF, 1'b1, 1'b0);
    send_frame(0, 8'hA5, 0);
    idle(2);
    chk("abandon_cnt", INPUTS'(frame_cnt), INPUTS'(8'd1));

    // Back-to-back frames, then enough more to wrap the frame counter.
    reset_check("rst4");
    send_frame(0, 8'hAA, 0);
    send_frame(0, 8'h0F, 0);
    idle(1);
    chk("b2b_cnt", INPUTS'(frame_cnt), INPUTS'(8'd2));
    chk("b2b_frame", frame_out, {(INPUTS/8){8'h0F}});
    for (int i = 0; i < 254; i++) send_frame(1, BYTE_W'($urandom), 0);
    idle(1);
    chk("wrap_cnt", INPUTS'(frame_cnt), '0);

    // Asynchronous reset mid-frame, then a clean frame.
    reset_check("rst5");
    for (int unsigned i = 0; i < 21; i++) drive(8'h11, 1'b1, i == 0);
    idle(1);
    chk("mid_idx", INPUTS'(beat_idx), INPUTS'(21));
    reset_check("rst_mid");
    send_frame(0, 8'h3C, 0);
    idle(2);
    chk("after_rst_cnt", INPUTS'(frame_cnt), INPUTS'(8'd1));
    chk("after_rst_frame", frame_out, {(INPUTS/8){8'h3C}});

    chk("sb_drained", INPUTS'(sb.size()), '0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/lgn_input_loader.md
Name: lgn_input_loader

Overview:
Upstream stage of the logic-gate-network classifier. Assembles a 256-bit binary image (16x16, 1 bit/pixel) from byte beats with a valid/start-of-frame strobe. The loaded image is double-buffered, so the combinational net and the category popcount/arg-max path see a stable frame while the next one loads. Emits a one-cycle commit pulse and a running frame counter for downstream result capture.

Parameters:
INPUTS, 256, image width in bits (net input vector width); must be a multiple of BYTE_W
BYTE_W, 8, beat width in bits
BEATS, INPUTS/BYTE_W (32), derived localparam, beats per frame
CNT_W, $clog2(BEATS) (5), derived localparam, beat counter width

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  asynchronous, active-high reset
in_data  input  BYTE_W  pixel byte, MSB = earliest pixel of the beat
in_valid  input  1  in_data valid this cycle
in_sof  input  1  qualifies a valid beat as byte 0 of a frame; ignored when in_valid=0
frame_out  output  INPUTS  committed image, feeds net input
frame_valid  output  1  one-cycle pulse, frame_out updated on the previous edge
busy  output  1  1 while a frame is partially loaded (state LOAD)
beat_idx  output  CNT_W  number of beats accepted in the current frame
sync_err  output  1  one-cycle pulse on framing violation
frame_cnt  output  8  count of committed frames, wraps 255->0

Behaviour:
- Interface: one clock (clk); reset rst is asynchronous and active-high. On assertion: frame_out=0, frame_valid=0, busy=0, beat_idx=0, sync_err=0, frame_cnt=0, shadow register=0, state=IDLE. Reset mid-frame discards the partial frame; frame_out returns to 0.
- Shadow register sh[INPUTS-1:0] shifts left by BYTE_W per accepted beat: sh <= {sh[INPUTS-BYTE_W-1:0], in_data}. After BEATS beats, byte 0 occupies [INPUTS-1:INPUTS-BYTE_W], and the last byte occupies [BYTE_W-1:0].
- FSM states: IDLE, LOAD.
- IDLE: in_valid & in_sof -> accept beat, beat_idx=1, go to LOAD. in_valid & ~in_sof -> beat dropped, sync_err pulse, stay IDLE. No valid -> hold.
- LOAD: in_valid & ~in_sof -> accept beat, beat_idx++. in_valid & in_sof -> partial frame abandoned, sync_err pulse, beat becomes byte 0 of a new frame, beat_idx=1, stay LOAD. No valid -> hold; gaps of any length are allowed.
- Commit: on the edge that accepts beat BEATS-1 (beat_idx==BEATS-1 & in_valid & ~in_sof): frame_out <= {sh[INPUTS-BYTE_W-1:0], in_data}, frame_cnt++, beat_idx=0, state=IDLE. frame_valid=1 for exactly the following cycle.
- Latency: last beat to frame_out/frame_valid is 1 clk.
- Back-to-back: in_valid & in_sof in the cycle right after the last beat starts the next frame without error. frame_out holds until the next commit.
- Degenerate case BEATS=1: every valid sof beat commits directly.
- frame_valid and sync_err are registered and never both high from the same beat. in_sof with in_valid=0 has no effect.
- Ignored in all states: no backpressure; every valid beat is consumed.

Decomposition:
- Shared package lgn_pkg: INPUTS, BYTE_W, derived BEATS, and the state enum {IDLE, LOAD}. The net top and the popcount/arg-max stage share INPUTS.
- No sub-module. Single flat block: FSM, counter, shadow shifter, output register.

Test Plan:
- Reset then 32 beats 0x00..0x1F, sof on first, gapless -> frame_valid pulse 1 clk after beat 31; frame_out[255:248]=0x00, [7:0]=0x1F; frame_cnt=1; busy low.
- Same frame with 3 random idle cycles between beats -> identical frame_out, commit 1 clk after last beat, beat_idx tracks 0..31.
- sof frame of 10 beats of 0xFF, then sof + 32 beats 0xA5 -> sync_err pulse on second sof; frame_out = all 0xA5 bytes; frame_cnt=1.
- Valid beat 0x55 without sof in IDLE -> sync_err pulse, busy stays 0, no frame_valid, frame_out unchanged.
- Two frames back-to-back (0xAA x32, then 0x0F x32, no gap) -> two frame_valid pulses 32 clk apart; frame_out=0xAA.. then 0x0F..; frame_cnt=2. Then 254 more frames -> frame_cnt wraps to 0.
- Assert rst asynchronously after beat 20 -> all outputs 0 immediately. A following full frame of 0x3C commits normally with frame_cnt=1.
